// File: rtl/pol2rec_pkg.sv
// Shared formats and constants for the CORDIC coordinate converters (16.16 magnitudes, 8.24 degree angles).
// Also holds the controller state encoding for pol2rec.
package pol2rec_pkg;

  localparam int MOD_W = 32;   // 16.16 signed magnitude / x / y
  localparam int ANG_W = 32;   // 8.24 signed degrees
  localparam int XY_W  = 34;   // x/y datapath: two guard bits over 16.16 for the CORDIC gain
  localparam int CNT_W = 5;    // iteration index, ITER <= 30

  localparam logic [ANG_W-1:0] DEG90  = 32'h5A000000;
  localparam logic [ANG_W-1:0] DEG180 = 32'hB4000000;  // unsigned; widened before use
  localparam logic [31:0]      INV_K  = 32'h4DBA76D4;  // 1/K = 0.6072529350 in Q1.31

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROT   = 2'd2,
    ST_SCALE = 2'd3
  } state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of atan(2^-idx) in degrees, 8.24 fixed point; entries from 24 up are zero.
// Latency: none (pure lookup).
// Backpressure: none; output follows idx.
module cordic_atan_rom
  import pol2rec_pkg::*;
(
  input  logic [CNT_W-1:0] idx,
  output logic [ANG_W-1:0] atan
);

  always_comb begin
    atan = '0;
    case (idx)
      5'd0:  atan = 32'd754974720;   // 45.0 deg
      5'd1:  atan = 32'd445687602;
      5'd2:  atan = 32'd235489088;
      5'd3:  atan = 32'd119537938;
      5'd4:  atan = 32'd60000934;
      5'd5:  atan = 32'd30029717;
      5'd6:  atan = 32'd15018523;
      5'd7:  atan = 32'd7509720;
      5'd8:  atan = 32'd3754917;
      5'd9:  atan = 32'd1877466;
      5'd10: atan = 32'd938734;
      5'd11: atan = 32'd469367;
      5'd12: atan = 32'd234684;
      5'd13: atan = 32'd117342;
      5'd14: atan = 32'd58671;
      5'd15: atan = 32'd29335;
      5'd16: atan = 32'd14668;
      5'd17: atan = 32'd7334;
      5'd18: atan = 32'd3667;
      5'd19: atan = 32'd1833;
      5'd20: atan = 32'd917;
      5'd21: atan = 32'd458;
      5'd22: atan = 32'd229;
      5'd23: atan = 32'd115;
      default: atan = '0;
    endcase
  end

endmodule

// File: rtl/pol2rec.sv
// Iterative rotation-mode CORDIC, polar (mod, angle) -> rectangular (x, y); GAIN_COMP_EN adds a 1/K scale state.
// Latency: ITER+2 enabled clocks start->done with GAIN_COMP_EN, ITER+1 without.
// Backpressure: enable=0 freezes every register; start while busy is dropped.
module pol2rec
  import pol2rec_pkg::*;
#(
  parameter int ITER = 24,
  parameter int ZW   = 34
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [MOD_W-1:0] mod,
  input  logic [ANG_W-1:0] angle,
  output logic [MOD_W-1:0] x,
  output logic [MOD_W-1:0] y,
  output logic             busy,
  output logic             done
);

  localparam logic signed [ZW-1:0] Z90  = $signed({{(ZW-ANG_W){1'b0}}, DEG90});
  localparam logic signed [ZW-1:0] Z180 = $signed({{(ZW-ANG_W){1'b0}}, DEG180});

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [XY_W-1:0]  xr, yr, xn, yn, xsh, ysh;
  logic signed [ZW-1:0]    zr, zn, atan_z;
  logic [ANG_W-1:0]        atan_v;
  logic                    last, fin, done_q;
  logic [MOD_W-1:0]        xfin, yfin;

  cordic_atan_rom u_atan_rom (
    .idx  (cnt),
    .atan (atan_v)
  );

  assign atan_z = $signed({{(ZW-ANG_W){1'b0}}, atan_v});
  assign last   = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      state <= ST_IDLE;
    else if (enable) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_ROT;
`ifdef GAIN_COMP_EN
      ST_ROT:   if (last) state_nxt = ST_SCALE;
      ST_SCALE: state_nxt = ST_IDLE;
`else
      ST_ROT:   if (last) state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One micro-rotation; d = +1 for z >= 0
  always_comb begin
    xsh = xr >>> cnt;
    ysh = yr >>> cnt;
    if (zr[ZW-1]) begin
      xn = xr + ysh;
      yn = yr - xsh;
      zn = zr + atan_z;
    end else begin
      xn = xr - ysh;
      yn = yr + xsh;
      zn = zr - atan_z;
    end
  end

`ifdef GAIN_COMP_EN
  localparam int                   PW  = XY_W + 33;
  localparam logic signed [PW-1:0] RND = PW'(64'sd1073741824);  // half LSB of the Q1.31 product
  logic signed [PW-1:0] kmul, px, py;

  always_comb begin
    kmul = PW'($signed({1'b0, INV_K}));
    px   = PW'(xr) * kmul + RND;
    py   = PW'(yr) * kmul + RND;
  end

  assign fin  = (state == ST_SCALE);
  assign xfin = px[62:31];
  assign yfin = py[62:31];
`else
  assign fin  = (state == ST_ROT) && last;
  assign xfin = xn[MOD_W-1:0];
  assign yfin = yn[MOD_W-1:0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      busy   <= 1'b0;
      done_q <= 1'b0;
    end else if (enable) begin
      case (state)
        ST_IDLE: if (start) begin
          xr   <= {{(XY_W-MOD_W){mod[MOD_W-1]}}, mod};
          yr   <= '0;
          zr   <= {{(ZW-ANG_W){angle[ANG_W-1]}}, angle};
          cnt  <= '0;
          busy <= 1'b1;
        end
        ST_LOAD: begin
          // Fold angles beyond +/-90 deg into the convergence range by negating x
          if (zr > Z90) begin
            xr <= -xr;
            zr <= zr - Z180;
          end else if (zr < -Z90) begin
            xr <= -xr;
            zr <= zr + Z180;
          end
          yr  <= '0;
          cnt <= '0;
        end
        ST_ROT: begin
          xr  <= xn;
          yr  <= yn;
          zr  <= zn;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
      done_q <= fin;
      if (fin) begin
        x    <= xfin;
        y    <= yfin;
        busy <= 1'b0;
      end
    end
  end

  // Gated so a pulse parked across a disabled stretch is seen on exactly one enabled clock
  assign done = done_q & enable;

endmodule
